// File: rtl/rv_pkg.sv
// RV32I field positions and opcode constants shared by the pipeline control blocks.
// Constants only; no logic, latency or flow control.
package rv_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;
  localparam int OPC_W   = 7;

  localparam int OPC_LSB = 0;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam logic [OPC_W-1:0] OP_RTYPE  = 7'h33;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'h03;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'h67;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'h17;

endpackage

// File: rtl/hazard_src_decode.sv
// Extracts rs1/rs2 and flags which source fields the ID-stage instruction really reads.
// Purely combinational, zero latency; no flow control.
module hazard_src_decode
  import rv_pkg::*;
(
  input  logic [INSTR_W-1:0] Instruction,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic               uses_rs1,
  output logic               uses_rs2
);

  logic [OPC_W-1:0] opcode;
  logic             unused_bits;

  assign opcode = Instruction[OPC_LSB +: OPC_W];
  assign rs1    = Instruction[RS1_LSB +: REG_W];
  assign rs2    = Instruction[RS2_LSB +: REG_W];

  // funct/imm/rd bits play no part in source-register usage.
  assign unused_bits = ^{Instruction[INSTR_W-1:RS2_LSB+REG_W],
                         Instruction[RS1_LSB-1:OPC_LSB+OPC_W]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        uses_rs1 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_u.sv
// Load-use hazard detect: stalls PC and IF/ID and bubbles ID/EX in the same cycle (combinational).
// Also counts stall cycles in a saturating counter cleared by synchronous reset.
module hazard_u
  import rv_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_W-1:0]   R_d,
  input  logic               MemRead,
  input  logic [INSTR_W-1:0] Instruction,
  output logic               SignalPC,
  output logic               IFID_hold,
  output logic               bubble,
  output logic [CNT_W-1:0]   stall_count
);

  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             hazard;

  hazard_src_decode u_decode (
    .Instruction (Instruction),
    .rs1         (rs1),
    .rs2         (rs2),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2)
  );

  // x0 is hard-wired zero, so a load targeting it can never create a dependency.
  assign hazard = MemRead && (R_d != '0) &&
                  ((uses_rs1 && (rs1 == R_d)) || (uses_rs2 && (rs2 == R_d)));

  assign SignalPC  = hazard;
  assign IFID_hold = hazard;
  assign bubble    = hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (hazard && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_u.sv
// Directed bench for hazard_u: literal checks plus a per-cycle reference model compare.
// Two instances share stimulus: default counter width and a 4-bit counter for saturation.
module tb_hazard_u;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  R_d;
  logic        MemRead;
  logic [31:0] Instruction;

  logic        pc_a, hold_a, bub_a;
  logic [15:0] cnt_a;
  logic        pc_b, hold_b, bub_b;
  logic [3:0]  cnt_b;

  int tests = 0;
  int fails = 0;

  int  m_cnt_a = 0;
  int  m_cnt_b = 0;
  bit  model_valid = 1'b0;

  always #5 clk = ~clk;

  hazard_u #(.INSTR_W(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .R_d(R_d), .MemRead(MemRead), .Instruction(Instruction),
    .SignalPC(pc_a), .IFID_hold(hold_a), .bubble(bub_a), .stall_count(cnt_a)
  );

  hazard_u #(.INSTR_W(32), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .R_d(R_d), .MemRead(MemRead), .Instruction(Instruction),
    .SignalPC(pc_b), .IFID_hold(hold_b), .bubble(bub_b), .stall_count(cnt_b)
  );

  // Reference: which opcodes read which source fields, as plain lists.
  function automatic bit in_list(input logic [6:0] op, input bit want_rs2);
    logic [6:0] rs1_ops [6];
    logic [6:0] rs2_ops [3];
    rs1_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    rs2_ops = '{7'h33, 7'h23, 7'h63};
    if (want_rs2) begin
      foreach (rs2_ops[i]) if (rs2_ops[i] == op) return 1'b1;
    end else begin
      foreach (rs1_ops[i]) if (rs1_ops[i] == op) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_hazard(input int rd, input bit mr, input logic [31:0] ins);
    int s1;
    int s2;
    s1 = int'(ins[19:15]);
    s2 = int'(ins[24:20]);
    if (!mr || rd == 0) return 1'b0;
    return (in_list(ins[6:0], 1'b0) && s1 == rd) || (in_list(ins[6:0], 1'b1) && s2 == rd);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model counters advance on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt_a     <= 0;
      m_cnt_b     <= 0;
      model_valid <= 1'b1;
    end else if (model_hazard(int'(R_d), MemRead, Instruction)) begin
      m_cnt_a <= (m_cnt_a < 65535) ? m_cnt_a + 1 : m_cnt_a;
      m_cnt_b <= (m_cnt_b < 15) ? m_cnt_b + 1 : m_cnt_b;
    end
  end

  always @(negedge clk) begin
    int h;
    h = int'(model_hazard(int'(R_d), MemRead, Instruction));
    check("cyc_pc_a",   int'(pc_a),   h);
    check("cyc_hold_a", int'(hold_a), h);
    check("cyc_bub_a",  int'(bub_a),  h);
    check("cyc_pc_b",   int'(pc_b),   h);
    if (model_valid) begin
      check("cyc_cnt_a", int'(cnt_a), m_cnt_a);
      check("cyc_cnt_b", int'(cnt_b), m_cnt_b);
    end
  end

  // Apply a vector, check the same-cycle stall literal, then let one clock edge pass.
  task automatic vec(input string name, input logic [4:0] rd, input logic mr,
                     input logic [31:0] ins, input int exp);
    R_d = rd;
    MemRead = mr;
    Instruction = ins;
    #1;
    check({name, "_pc"}, int'(pc_a), exp);
    check({name, "_hold"}, int'(hold_a), exp);
    check({name, "_bub"}, int'(bub_a), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    R_d = 5'd0;
    MemRead = 1'b0;
    Instruction = 32'h0000_0000;
    #1;
    check("idle_pre_clk_pc", int'(pc_a), 0);
    check("idle_pre_clk_bub", int'(bub_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_cnt_a", int'(cnt_a), 0);
    check("reset_cnt_b", int'(cnt_b), 0);

    vec("idle",        5'd0,  1'b0, 32'h0000_0000, 0);
    vec("addi_miss",   5'd10, 1'b1, 32'h8A62_0013, 0);
    vec("addi_hit",    5'd4,  1'b1, 32'h8A62_0013, 1);
    check("addi_hit_cnt", int'(cnt_a), 1);
    vec("addi_rs2fld", 5'd6,  1'b1, 32'h8A62_0013, 0);
    vec("rtype_rs2",   5'd10, 1'b1, 32'h00A4_8433, 1);
    vec("rtype_rs1",   5'd9,  1'b1, 32'h00A4_8433, 1);
    vec("rtype_nomr",  5'd10, 1'b0, 32'h00A4_8433, 0);
    vec("rtype_x0",    5'd0,  1'b1, 32'h0000_0033, 0);
    vec("lui",         5'd20, 1'b1, 32'h000A_0537, 0);
    vec("jal",         5'd0,  1'b1, 32'h0000_006F, 0);
    check("after_vecs_cnt", int'(cnt_a), 3);

    // Reset while a hazard is present: counter clears, stall outputs keep following inputs.
    R_d = 5'd4;
    MemRead = 1'b1;
    Instruction = 32'h8A62_0013;
    rst = 1'b1;
    #1;
    check("rst_hazard_pc", int'(pc_a), 1);
    clocks(1);
    check("rst_clear_a", int'(cnt_a), 0);
    rst = 1'b0;
    clocks(5);
    check("hold5_a", int'(cnt_a), 5);
    check("hold5_b", int'(cnt_b), 5);
    rst = 1'b1;
    clocks(1);
    check("midstall_rst_a", int'(cnt_a), 0);
    check("midstall_rst_b", int'(cnt_b), 0);
    rst = 1'b0;
    clocks(3);
    check("resume_a", int'(cnt_a), 3);
    clocks(17);
    check("long_a", int'(cnt_a), 20);
    check("sat_b", int'(cnt_b), 15);

    vec("final_idle", 5'd0, 1'b0, 32'h0000_0000, 0);
    check("final_hold_b", int'(cnt_b), 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_u.md
Name: hazard_u

Overview:
Load-use hazard detection unit for the 5-stage RV32I pipeline.
- Compares the destination register of the load in EX (R_d, MemRead) against the source registers actually used by the instruction in ID.
- On a match it stalls PC and IF/ID and injects a bubble into ID/EX.
- The detection path is purely combinational. A small clocked block keeps a saturating stall-event counter for performance monitoring.

Parameters:
- INSTR_W, 32, instruction width; only 32 is supported.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- R_d  in  5  destination register of the instruction in EX.
- MemRead  in  1  the instruction in EX is a load.
- Instruction  in  32  raw instruction currently in the ID stage.
- SignalPC  out  1  1 = hold PC (PC write disabled); 0 = PC advances.
- IFID_hold  out  1  1 = hold the IF/ID register; identical to SignalPC.
- bubble  out  1  1 = zero the ID/EX control signals; identical to SignalPC.
- stall_count  out  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- Field decode of Instruction:
  - opcode = [6:0]
  - rs1 = [19:15]
  - rs2 = [24:20]
- uses_rs1 = 1 for these opcodes:
  - 0x33 (R), 0x13 (I-ALU), 0x03 (load), 0x23 (store), 0x63 (branch), 0x67 (JALR).
  - 0 for all others: LUI 0x37, AUIPC 0x17, JAL 0x6F, SYSTEM, unknown.
- uses_rs2 = 1 only for opcodes 0x33, 0x23, 0x63.
- hazard = MemRead AND (R_d != 0) AND ((uses_rs1 AND rs1 == R_d) OR (uses_rs2 AND rs2 == R_d)).
- SignalPC = IFID_hold = bubble = hazard. Purely combinational, same-cycle, no dependence on clk or rst.
- Outputs are valid any time inputs are stable, including before the first clock edge.
- Register x0 never causes a stall, even when R_d = 0 and a source field is 0.
- MemRead = 0 gives no stall regardless of register match.
- Unused source fields never cause a stall; e.g. the rs2 field of an I-type instruction is ignored.
- stall_count:
  - On a rising clk with rst = 1, it becomes 0.
  - Otherwise, if hazard = 1 and stall_count is below its maximum, it increments by 1.
  - At 2^CNT_W-1 it holds; no wrap.
  - Reset mid-stall clears the counter. Combinational hazard outputs still follow their inputs during reset.
- Reset value of every registered output: stall_count = 0. Combinational outputs have no reset value.
- One stall cycle per load-use pair: the pipeline clears MemRead in EX via the bubble on the next cycle. This unit does not track that.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants: OP_RTYPE = 7'h33, OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_BRANCH = 7'h63, OP_JALR = 7'h67, OP_JAL = 7'h6F, OP_LUI = 7'h37, OP_AUIPC = 7'h17.
  - field-position localparams for rs1 and rs2.
- One sub-module is natural: hazard_src_decode.
  - Input: Instruction.
  - Outputs: rs1, rs2, uses_rs1, uses_rs2.
  - The top holds the compare logic and the counter.

Test Plan:
- Idle: R_d = 0, MemRead = 0, Instruction = 0x00000000 -> SignalPC = 0, bubble = 0; after rst pulse, stall_count = 0.
- ADDI with rs1 = 4: R_d = 10, MemRead = 1, Instruction = 0x8A620013 -> SignalPC = 0 (rs1 = 4; rs2 field 6 is unused).
- ADDI hit: R_d = 4, MemRead = 1, Instruction = 0x8A620013 -> SignalPC = 1, IFID_hold = 1, bubble = 1, same cycle; stall_count increments by 1 at the next clk edge.
- R-type rs2 hit: Instruction = 0x00A48433 (add x8, x9, x10), R_d = 10, MemRead = 1 -> SignalPC = 1. Same with MemRead = 0 -> 0. Same with R_d = 0 and Instruction = 0x00000033 -> 0 (x0 rule).
- Opcodes without rs1/rs2: LUI 0x000A0537, R_d = 20, MemRead = 1 -> SignalPC = 0. JAL 0x0000006F, R_d = 0 -> 0.
- Counter: hold a hazard for 5 clocks -> stall_count = 5. Assert rst for 1 clock during the hazard -> 0, then resumes counting. With CNT_W = 4, hold the hazard for 20 clocks -> saturates at 15.
